// File: rtl/e_mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit.
// The D-stage decoder imports the same MDU_Op values.
package e_mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Result is formed at start; a down-counter models latency.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDU_Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e        r_state;
    mdu_state_e        w_next;
    logic [CNT_W-1:0]  r_count;
    logic [63:0]       r_pend;
    logic              r_divz;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_idle;
    logic              w_last;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_mthi;
    logic              w_is_mtlo;
    logic [63:0]       w_res;
    logic [63:0]       w_mul_s;
    logic [63:0]       w_mul_u;
    logic signed [31:0] w_qs;
    logic signed [31:0] w_rs;
    logic [31:0]       w_qu;
    logic [31:0]       w_ru;
    logic              w_ovf;

    assign w_idle = (r_state == MDU_IDLE);
    assign w_last = (r_state == MDU_BUSY) && (r_count == CNT_W'(1));

    always_comb begin
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_is_mthi = 1'b0;
        w_is_mtlo = 1'b0;
        case (MDU_Op)
            MDU_MULT,
            MDU_MULTU: w_is_mul  = 1'b1;
            MDU_DIV,
            MDU_DIVU:  w_is_div  = 1'b1;
            MDU_MTHI:  w_is_mthi = 1'b1;
            MDU_MTLO:  w_is_mtlo = 1'b1;
            default:   ;
        endcase
    end

    assign w_mul_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign w_mul_u = {32'b0, SrcA} * {32'b0, SrcB};
    assign w_qs    = $signed(SrcA) / $signed(SrcB);
    assign w_rs    = $signed(SrcA) % $signed(SrcB);
    assign w_qu    = SrcA / SrcB;
    assign w_ru    = SrcA % SrcB;
    // -2^31 / -1 does not fit; pin the architected result
    assign w_ovf   = (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);

    always_comb begin
        w_res = 64'b0;
        case (MDU_Op)
            MDU_MULT:  w_res = w_mul_s;
            MDU_MULTU: w_res = w_mul_u;
            MDU_DIV:   w_res = w_ovf ? {32'b0, 32'h8000_0000}
                                     : {w_rs, w_qs};
            MDU_DIVU:  w_res = {w_ru, w_qu};
            default:   w_res = 64'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MDU_IDLE:
                if (start && (w_is_mul || w_is_div))
                    w_next = MDU_BUSY;
            MDU_BUSY:
                if (w_last)
                    w_next = MDU_IDLE;
            default: w_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_pend  <= '0;
            r_divz  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_idle) begin
            if (start && w_is_mul) begin
                r_count <= CNT_W'(MUL_CYCLES);
                r_pend  <= w_res;
                r_divz  <= 1'b0;
            end else if (start && w_is_div) begin
                r_count <= CNT_W'(DIV_CYCLES);
                r_pend  <= w_res;
                r_divz  <= (SrcB == 32'b0);
            end else if (start && w_is_mthi) begin
                r_hi <= SrcA;
            end else if (start && w_is_mtlo) begin
                r_lo <= SrcA;
            end
        end else begin
            r_count <= r_count - CNT_W'(1);
            if (w_last && !r_divz) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
        end
    end

    assign busy = (r_state == MDU_BUSY);
    assign done = w_last;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, done pulse, HI/LO results.
// Inputs change on the falling edge; outputs are checked there too.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  MDU_Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .MDU_Op (MDU_Op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] eh,
                       input logic [31:0] el, input bit inj);
        int bcnt;
        int dcnt;
        int dat;
        int lim;
        logic [31:0] oh;
        logic [31:0] ol;
        oh = HI;
        ol = LO;
        @(negedge clk);
        MDU_Op = op;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        dcnt = 0;
        dat  = 0;
        lim  = 0;
        while (busy === 1'b1 && lim < 40) begin
            bcnt++;
            if (done === 1'b1) begin
                dcnt++;
                dat = bcnt;
            end
            if (bcnt == 1) begin
                chk({tag, "_midHI"}, HI, oh);
                chk({tag, "_midLO"}, LO, ol);
            end
            if (inj && bcnt == 2) begin
                MDU_Op = MDU_DIV;
                SrcA   = 32'd100;
                SrcB   = 32'd7;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lim++;
        end
        start = 1'b0;
        chk({tag, "_busycyc"}, 32'(bcnt), 32'(n));
        chk({tag, "_donecnt"}, 32'(dcnt), 32'd1);
        chk({tag, "_doneat"}, 32'(dat), 32'(n));
        chk({tag, "_HI"}, HI, eh);
        chk({tag, "_LO"}, LO, el);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        MDU_Op  = 3'b000;
        SrcA    = '0;
        SrcB    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        reset_n = 1'b1;

        @(negedge clk);
        MDU_Op = MDU_MTHI;
        SrcA   = 32'h1234_5678;
        start  = 1'b1;
        @(negedge clk);
        chk("mthi_HI", HI, 32'h1234_5678);
        chk("mthi_LO", LO, 32'd0);
        chk("mthi_busy", 32'(busy), 32'd0);
        MDU_Op = MDU_MTLO;
        SrcA   = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_LO", LO, 32'h9ABC_DEF0);
        chk("mtlo_HI", HI, 32'h1234_5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        chk("mtlo_done", 32'(done), 32'd0);

        @(negedge clk);
        MDU_Op = 3'b110;
        SrcA   = 32'hDEAD_BEEF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_HI", HI, 32'h1234_5678);
        chk("nop_LO", LO, 32'h9ABC_DEF0);

        @(negedge clk);
        MDU_Op = MDU_MULT;
        SrcA   = 32'd9;
        SrcB   = 32'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_HI_hold", HI, 32'd0);
        chk("midrst_LO_hold", LO, 32'd0);
        reset_n = 1'b1;

        run("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5,
            32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5,
            32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu", MDU_DIVU, 32'd7, 32'd2, 10,
            32'd1, 32'd3, 1'b0);
        run("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
            32'd0, 32'h8000_0000, 1'b0);
        run("divz", MDU_DIVU, 32'd5, 32'd0, 10,
            32'd0, 32'h8000_0000, 1'b0);
        run("ignore", MDU_MULT, 32'd2, 32'd3, 5,
            32'd0, 32'd6, 1'b1);
        @(negedge clk);
        chk("ignore_idle", 32'(busy), 32'd0);
        chk("ignore_nodone", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
